// File: rtl/csr2_arb_pkg.sv
// Shared constants, FSM state type and bank-image helper for the CSR bank arbiter.
package csr2_arb_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_REGS   = 4;
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int CSR_ADDR_W = 4;
  localparam int BANK_W     = NUM_REGS * WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT0 = 2'd2,
    WAIT1 = 2'd3
  } state_t;

  // Returns the bank image with one word replaced (read-modify-write of the shadow).
  function automatic logic [BANK_W-1:0] put_word(input logic [BANK_W-1:0] image,
                                                 input logic [IDX_W-1:0]  idx,
                                                 input logic [WORD_W-1:0] word);
    logic [BANK_W-1:0] res;
    res = image;
    res[idx*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/csr2_bank_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/csr2_bank_arbiter.sv
// Shares the 4x32 CSR bank between NUM_REQ word-wide requesters; one transaction
// in flight, fixed 4-cycle accept-to-response latency, writes via a shadow image.
module csr2_bank_arbiter
  import csr2_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*IDX_W-1:0]  req_addr,
  input  logic [NUM_REQ*WORD_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      csr2_we,
  output logic [BANK_W-1:0]         csr2_wdata,
  input  logic [BANK_W-1:0]         csr2_rdata,
  output logic [CSR_ADDR_W-1:0]     csr2_addr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic               accept;
  logic               win_write;
  logic [IDX_W-1:0]   win_addr;
  logic [IDX_W-1:0]   sel_addr;
  logic [WORD_W-1:0]  sel_wdata;
  logic [BANK_W-1:0]  shadow;

  assign arb_en = rst_n && (state == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign sel_addr  = req_addr[gnt_idx*IDX_W +: IDX_W];
  assign sel_wdata = req_wdata[gnt_idx*WORD_W +: WORD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
      win_idx    <= '0;
      win_write  <= 1'b0;
      win_addr   <= '0;
      shadow     <= '0;
      csr2_we    <= 1'b0;
      csr2_wdata <= '0;
      csr2_addr  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      csr2_we   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            win_idx   <= gnt_idx;
            win_write <= req_write[gnt_idx];
            win_addr  <= sel_addr;
            rr_ptr    <= gnt_idx;
            csr2_addr <= {{(CSR_ADDR_W-IDX_W){1'b0}}, sel_addr};
            if (req_write[gnt_idx]) begin
              csr2_we    <= 1'b1;
              csr2_wdata <= put_word(shadow, sel_addr, sel_wdata);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (win_write) shadow <= csr2_wdata;
          state <= WAIT0;
        end
        WAIT0: state <= WAIT1;
        WAIT1: begin
          // Bank readback is registered, so it reflects the write only now.
          rsp_rdata          <= csr2_rdata[win_addr*WORD_W +: WORD_W];
          rsp_valid[win_idx] <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
